key_conditioner: RTL
====================

# key_conditioner

Input conditioning stage for one active-low push button, sitting directly upstream of the `watch` mode/setting controller; one instance per key. It synchronises the raw pin, debounces press and release, and produces a clean level plus single-cycle press, release and long-press events, which the controller consumes in place of its own hold counters. All outputs are registered.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required to accept a press or release (20 ms at 50 MHz); legal range ≥ 2.
- `LONG_PRESS_CYCLES`, default 200_000_000: cycles in the accepted-pressed state before `long_pulse` fires; legal range ≥ 2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `key_n`  input  1  raw button pin, asynchronous, active low.
- `key_clean`  output  1  debounced level; 1 = pressed.
- `press_pulse`  output  1  one-cycle pulse on each accepted press.
- `release_pulse`  output  1  one-cycle pulse on each accepted release.
- `long_pulse`  output  1  one-cycle pulse, at most once per press, when the hold reaches `LONG_PRESS_CYCLES`.
- `was_long`  output  1  latched with `release_pulse`: 1 if `long_pulse` fired during that press; held until the next `press_pulse`.

## Operation
- `key_sync` = `~key_n` through a 2-flop synchroniser; the synchroniser flops reset to 0.
- FSM states: `IDLE`, `DEB_PRESS`, `PRESSED`, `LONG_HELD`, `DEB_RELEASE`.
- `IDLE`: when `key_sync`=1, go to `DEB_PRESS` and clear `deb_cnt`.
- `DEB_PRESS`: when `key_sync`=0, go back to `IDLE` with no event. Otherwise increment `deb_cnt`. When `deb_cnt`=`DEBOUNCE_CYCLES`-1, go to `PRESSED`, set `key_clean`, pulse `press_pulse`, clear `hold_cnt`, clear `long_fired` and clear `was_long`.
- `PRESSED`: `hold_cnt` increments every cycle. When `hold_cnt`=`LONG_PRESS_CYCLES`-1, pulse `long_pulse`, set `long_fired` and go to `LONG_HELD`. `key_sync`=0 takes priority: go to `DEB_RELEASE` and clear `deb_cnt`.
- `LONG_HELD`: counter frozen. `key_sync`=0 goes to `DEB_RELEASE` and clears `deb_cnt`.
- `DEB_RELEASE`:
  - `hold_cnt` is frozen.
  - If `key_sync`=1 (bounce), return to `PRESSED` or `LONG_HELD` according to `long_fired`, with no event.
  - When `deb_cnt`=`DEBOUNCE_CYCLES`-1, go to `IDLE`, clear `key_clean`, pulse `release_pulse` and load `was_long` from `long_fired`.
- Counter widths are `$clog2(param)+1`. No counter wraps: `deb_cnt` stops at its terminal value and `hold_cnt` stops at `LONG_PRESS_CYCLES`-1.
- `press_pulse`, `long_pulse` and `release_pulse` are mutually exclusive by construction.

## Timing
- Reset (`rst`=1 at an edge):
  - State goes to `IDLE`.
  - All counters clear.
  - `key_clean`, `press_pulse`, `release_pulse`, `long_pulse` and `was_long` all go to 0.
  - Reset mid-press: no release event. A key still held after reset is debounced as a new press.
- Edge 0 is the first edge sampling `key_n`=0, with the key held stable afterwards:
  - `key_sync` = 1 after edge 1.
  - `DEB_PRESS` is entered at edge 2.
  - `press_pulse` and `key_clean` rise after edge `DEBOUNCE_CYCLES`+2.
  - `long_pulse` is high in the single cycle after edge `DEBOUNCE_CYCLES`+2+`LONG_PRESS_CYCLES`.
- Release has the same structure: `release_pulse` and the fall of `key_clean` occur `DEBOUNCE_CYCLES`+2 edges after the first edge sampling `key_n`=1.
- A low glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- Release bounce during `PRESSED` freezes, but does not reset, the long-press time.

## Structure
- Shared package `watch_pkg` holds:
  - typedef enum `key_state_t`.
  - Default constants `C_DEBOUNCE` and `C_LONG_PRESS`, which `watch` also uses.
- Sub-module `sync_2ff`: a single-bit two-flop synchroniser with `clk`/`rst`, reusable for other pins.
- The FSM, counters and output registers live in `key_conditioner`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=20.
- Clean press held 10 cycles, then release: `press_pulse` high exactly one cycle after edge 6; `release_pulse` one cycle after edge 6 relative to release; `was_long`=0; no `long_pulse`.
- Press held 40 cycles: `long_pulse` exactly once, after edge 26; release gives `release_pulse` with `was_long`=1.
- Press with 3-cycle low glitches repeated every 5 cycles: no `press_pulse`; `key_clean` stays 0.
- Accepted press, then a 2-cycle high bounce at hold count 10, then held: `long_pulse` delayed by exactly 2 cycles; no `release_pulse`.
- `rst` asserted for 1 cycle while in `LONG_HELD`: all outputs 0 next cycle; no `release_pulse`; key still held gives a new `press_pulse` 6 edges after reset deasserts.
- After a long press, a short press follows: `was_long` clears at the new `press_pulse` and reads 0 at its release.

Source files
------------

// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
//
// Definitions shared between the watch controller and its input conditioning
// stages.
//   key_state_t   : state encoding of the per-key debounce / hold FSM
//   C_DEBOUNCE    : default debounce length in clk cycles (20 ms at 50 MHz)
//   C_LONG_PRESS  : default long-press length in clk cycles (4 s at 50 MHz)
//   cnt_width()   : width of a counter that must hold values 0..n
// -----------------------------------------------------------------------------
package watch_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      DEB_PRESS   = 3'd1,
      PRESSED     = 3'd2,
      LONG_HELD   = 3'd3,
      DEB_RELEASE = 3'd4
   } key_state_t;

   localparam int unsigned C_DEBOUNCE   = 1_000_000;
   localparam int unsigned C_LONG_PRESS = 200_000_000;

   // One spare bit above $clog2 so a counter can reach n itself, not just n-1.
   function automatic int cnt_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Single-bit two-flop synchroniser for an asynchronous input pin.
//   clk : destination clock
//   rst : synchronous, active-high reset; both stages clear to 0
//   d   : asynchronous input
//   q   : synchronised output, two clk edges of latency
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic stage1_q, stage1_d;
   logic stage2_q, stage2_d;

   always_comb begin
      stage1_d = d;
      stage2_d = stage1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage1_q <= 1'b0;
         stage2_q <= 1'b0;
      end else begin
         stage1_q <= stage1_d;
         stage2_q <= stage2_d;
      end
   end

   assign q = stage2_q;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Conditions one active-low push button: synchronises the pin, debounces
// press and release, and produces a clean level plus single-cycle press,
// release and long-press events. All outputs are registered.
//
// Parameters
//   DEBOUNCE_CYCLES   : stable cycles needed to accept a press or release (>=2)
//   LONG_PRESS_CYCLES : cycles held after acceptance before long_pulse (>=2)
// Ports
//   clk           : system clock, rising edge
//   rst           : synchronous, active-high reset
//   key_n         : raw button pin, asynchronous, active low
//   key_clean     : debounced level, 1 = pressed
//   press_pulse   : one cycle on each accepted press
//   release_pulse : one cycle on each accepted release
//   long_pulse    : one cycle, at most once per press, at the long-press time
//   was_long      : captured at release: 1 if long_pulse fired in that press;
//                   held until the next press_pulse
// -----------------------------------------------------------------------------
module key_conditioner
   import watch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = C_DEBOUNCE,
   parameter int unsigned LONG_PRESS_CYCLES = C_LONG_PRESS
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_clean,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic was_long
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int HW = cnt_width(LONG_PRESS_CYCLES);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

   logic key_sync;

   key_state_t    state_q, state_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          long_fired_q, long_fired_d;
   logic          key_clean_q, key_clean_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;
   logic          was_long_q, was_long_d;

   // Pin is active low; invert before synchronising so key_sync = 1 means pressed.
   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (~key_n),
      .q   (key_sync)
   );

   always_comb begin
      state_d      = state_q;
      deb_cnt_d    = deb_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      long_fired_d = long_fired_q;
      key_clean_d  = key_clean_q;
      was_long_d   = was_long_q;
      press_d      = 1'b0;
      release_d    = 1'b0;
      long_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (key_sync) begin
               state_d   = DEB_PRESS;
               deb_cnt_d = '0;
            end
         end

         DEB_PRESS: begin
            if (!key_sync) begin
               state_d = IDLE;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d      = PRESSED;
               key_clean_d  = 1'b1;
               press_d      = 1'b1;
               hold_cnt_d   = '0;
               long_fired_d = 1'b0;
               was_long_d   = 1'b0;
            end else begin
               deb_cnt_d = deb_cnt_q + DW'(1);
            end
         end

         PRESSED: begin
            // The hold count advances on every PRESSED cycle, including the
            // one that leaves for DEB_RELEASE; it saturates at HOLD_LAST so a
            // bounce right at the threshold still fires long_pulse on return.
            if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
            if (!key_sync) begin
               state_d   = DEB_RELEASE;
               deb_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d      = LONG_HELD;
               long_d       = 1'b1;
               long_fired_d = 1'b1;
            end
         end

         LONG_HELD: begin
            if (!key_sync) begin
               state_d   = DEB_RELEASE;
               deb_cnt_d = '0;
            end
         end

         DEB_RELEASE: begin
            if (key_sync) begin
               // Release bounce: resume where we were, hold time preserved.
               state_d = long_fired_q ? LONG_HELD : PRESSED;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d     = IDLE;
               key_clean_d = 1'b0;
               release_d   = 1'b1;
               was_long_d  = long_fired_q;
            end else begin
               deb_cnt_d = deb_cnt_q + DW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         deb_cnt_q    <= '0;
         hold_cnt_q   <= '0;
         long_fired_q <= 1'b0;
         key_clean_q  <= 1'b0;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         long_q       <= 1'b0;
         was_long_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         deb_cnt_q    <= deb_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         long_fired_q <= long_fired_d;
         key_clean_q  <= key_clean_d;
         press_q      <= press_d;
         release_q    <= release_d;
         long_q       <= long_d;
         was_long_q   <= was_long_d;
      end
   end

   assign key_clean     = key_clean_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;
   assign was_long      = was_long_q;

endmodule
